// File: rtl/scc_mem_pkg.sv
// Shared types and constants for the data-memory responder.
package scc_mem_pkg;

    // Responder FSM: one request in flight, one cycle of array access.
    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_RESP   = 2'd2
    } state_e;

    localparam int unsigned DEFAULT_DEPTH = 256;
    localparam logic [31:0] DEFAULT_BASE  = 32'h0000_0000;

    // err_count sticks here once reached.
    localparam logic [15:0] ERR_COUNT_MAX = 16'hFFFF;

endpackage

// File: rtl/mem_array.sv
// Single-port DEPTH x 32 synchronous array with byte-enable writes.
// Contents are deliberately not reset; the read register holds its value
// between accesses so read data stays stable while a response waits.
module mem_array #(
    parameter  int unsigned DEPTH = 256,
    localparam int unsigned AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic          clk,
    input  logic          en,
    input  logic          we,
    input  logic [3:0]    be,
    input  logic [AW-1:0] addr,
    input  logic [31:0]   wdata,
    output logic [31:0]   rdata
);

    logic [31:0] mem [DEPTH];
    logic [31:0] rdata_q;

    // One access per enabled cycle: byte-masked write, or registered read.
    always_ff @(posedge clk) begin
        if (en) begin
            if (we) begin
                for (int i = 0; i < 4; i++) begin
                    if (be[i]) begin
                        mem[addr][8*i +: 8] <= wdata[8*i +: 8];
                    end
                end
            end else begin
                rdata_q <= mem[addr];
            end
        end
    end

    assign rdata = rdata_q;

endmodule

// File: rtl/data_mem_responder.sv
// Data-memory responder: accepts one request at a time, checks alignment
// and range, performs the access in a single ACCESS cycle and holds the
// response in RESP until the core takes it.
//
// Handshake: a request transfers on a rising edge where req_valid and
// req_ready are both 1; a response transfers on a rising edge where
// rsp_valid and rsp_ready are both 1. rsp_rdata/rsp_err are stable for as
// long as rsp_valid is held.
module data_mem_responder
    import scc_mem_pkg::*;
#(
    parameter int unsigned DEPTH = DEFAULT_DEPTH,
    parameter logic [31:0] BASE  = DEFAULT_BASE
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    input  logic [3:0]  req_be,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err,
    output logic [15:0] err_count,
    output state_e      dbg_state
);

    localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    state_e      state_q, state_d;
    logic        write_q, write_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic [3:0]  be_q, be_d;
    logic [15:0] err_count_q, err_count_d;

    logic        accept;
    logic [31:0] word_full;
    logic        addr_err;
    logic [31:0] mem_rdata;

    assign accept = req_valid && req_ready;

    // Range check on the latched address; subtraction wraps at 32 bits, so
    // an address below BASE is caught explicitly rather than by the compare.
    assign word_full = (addr_q - BASE) >> 2;
    assign addr_err  = (addr_q[1:0] != 2'b00) || (addr_q < BASE) ||
                       (word_full >= 32'(DEPTH));

    mem_array #(
        .DEPTH (DEPTH)
    ) u_mem (
        .clk   (clk),
        .en    ((state_q == ST_ACCESS) && !addr_err),
        .we    (write_q),
        .be    (be_q),
        .addr  (word_full[AW-1:0]),
        .wdata (wdata_q),
        .rdata (mem_rdata)
    );

    // State, request latch and error counter; reset aborts any transaction.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= ST_IDLE;
            write_q     <= 1'b0;
            addr_q      <= '0;
            wdata_q     <= '0;
            be_q        <= '0;
            err_count_q <= '0;
        end else begin
            state_q     <= state_d;
            write_q     <= write_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            be_q        <= be_d;
            err_count_q <= err_count_d;
        end
    end

    // Next state: IDLE -> ACCESS on accept, ACCESS -> RESP always,
    // RESP -> IDLE on response handshake.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE:   if (accept)    state_d = ST_ACCESS;
            ST_ACCESS:                state_d = ST_RESP;
            ST_RESP:   if (rsp_ready) state_d = ST_IDLE;
            default:                  state_d = ST_IDLE;
        endcase
    end

    // Request latch and saturating error count.
    always_comb begin
        write_d     = write_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        be_d        = be_q;
        err_count_d = err_count_q;
        if (accept) begin
            write_d = req_write;
            addr_d  = req_addr;
            wdata_d = req_wdata;
            be_d    = req_be;
        end
        if ((state_q == ST_ACCESS) && addr_err && (err_count_q != ERR_COUNT_MAX)) begin
            err_count_d = err_count_q + 16'd1;
        end
    end

    // Outputs decoded from state; req_ready is held low while in reset.
    always_comb begin
        req_ready = reset && (state_q == ST_IDLE);
        rsp_valid = (state_q == ST_RESP);
        rsp_err   = rsp_valid && addr_err;
        rsp_rdata = '0;
        if (rsp_valid && !addr_err && !write_q) begin
            rsp_rdata = mem_rdata;
        end
        err_count = err_count_q;
        dbg_state = state_q;
    end

endmodule

// File: tb/tb_data_mem_responder.sv
// Directed bench for data_mem_responder: driver tasks issue requests and
// push the expected {err, rdata} into exp_q; a negedge monitor pops and
// compares on every response handshake.
module tb_data_mem_responder;
    import scc_mem_pkg::*;

    logic        clk = 1'b0;
    logic        reset;
    logic        req_valid;
    logic        req_ready;
    logic        req_write;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic [3:0]  req_be;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_rdata;
    logic        rsp_err;
    logic [15:0] err_count;
    state_e      dbg_state;

    logic [32:0] exp_q[$];
    logic [32:0] mon_exp;
    int          n_cmp  = 0;
    int          n_fail = 0;

    data_mem_responder #(
        .DEPTH (256),
        .BASE  (32'h0000_0000)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_write (req_write),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .req_be    (req_be),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_rdata (rsp_rdata),
        .rsp_err   (rsp_err),
        .err_count (err_count),
        .dbg_state (dbg_state)
    );

    // Clock
    always #5 clk = ~clk;

    // Watchdog
    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Monitor: a response is sampled mid-cycle when valid and ready are both high.
    always @(negedge clk) begin
        if (reset === 1'b1 && rsp_valid === 1'b1 && rsp_ready === 1'b1) begin
            if (exp_q.size() == 0) begin
                n_cmp++;
                n_fail++;
                $display("FAIL unexpected_rsp: got err=%0b rdata=%0h expected no response", rsp_err, rsp_rdata);
            end else begin
                mon_exp = exp_q.pop_front();
                check("rsp_err", {63'd0, rsp_err}, {63'd0, mon_exp[32]});
                check("rsp_rdata", {32'd0, rsp_rdata}, {32'd0, mon_exp[31:0]});
            end
        end
    end

    // Issue one request; caller is at posedge+1. Returns at posedge+1 after
    // the response drains (wait_rsp) or right after rsp_valid rises.
    task automatic do_req(input logic wr, input logic [31:0] addr, input logic [31:0] wdata,
                          input logic [3:0] be, input logic exp_err, input logic [31:0] exp_rdata,
                          input bit wait_rsp);
        int budget;
        budget = 0;
        while (req_ready !== 1'b1 && budget < 50) begin
            @(posedge clk); #1;
            budget++;
        end
        check("req_ready_before_req", {63'd0, req_ready}, 64'd1);
        req_valid = 1'b1;
        req_write = wr;
        req_addr  = addr;
        req_wdata = wdata;
        req_be    = be;
        exp_q.push_back({exp_err, exp_rdata});
        @(posedge clk); #1;
        req_valid = 1'b0;
        req_write = 1'($urandom_range(0, 1));
        req_addr  = $urandom;
        req_wdata = $urandom;
        req_be    = 4'($urandom_range(0, 15));
        check("accept_state", {62'd0, dbg_state}, {62'd0, ST_ACCESS});
        check("lat_valid_n1", {63'd0, rsp_valid}, 64'd0);
        @(posedge clk); #1;
        check("lat_valid_n2", {63'd0, rsp_valid}, 64'd1);
        if (wait_rsp) begin
            budget = 0;
            while (rsp_valid === 1'b1 && budget < 50) begin
                @(posedge clk); #1;
                budget++;
            end
            check("rsp_drained", {63'd0, rsp_valid}, 64'd0);
        end
    endtask

    initial begin
        reset     = 1'b0;
        req_valid = 1'b0;
        req_write = 1'b0;
        req_addr  = '0;
        req_wdata = '0;
        req_be    = '0;
        rsp_ready = 1'b1;

        // Reset values
        repeat (3) @(posedge clk);
        #1;
        check("rst_req_ready", {63'd0, req_ready}, 64'd0);
        check("rst_rsp_valid", {63'd0, rsp_valid}, 64'd0);
        check("rst_rsp_rdata", {32'd0, rsp_rdata}, 64'd0);
        check("rst_rsp_err",   {63'd0, rsp_err}, 64'd0);
        check("rst_err_count", {48'd0, err_count}, 64'd0);
        check("rst_state",     {62'd0, dbg_state}, {62'd0, ST_IDLE});
        reset = 1'b1;
        #1;
        check("ready_after_reset", {63'd0, req_ready}, 64'd1);
        @(posedge clk); #1;

        // Word 0 preload, write/read back, last word boundary
        do_req(1'b1, 32'h0000_0000, 32'h55AA_55AA, 4'hF, 1'b0, 32'h0, 1'b1);
        do_req(1'b1, 32'h0000_0010, 32'hDEAD_BEEF, 4'hF, 1'b0, 32'h0, 1'b1);
        do_req(1'b0, 32'h0000_0010, 32'h0,         4'h0, 1'b0, 32'hDEAD_BEEF, 1'b1);
        do_req(1'b1, 32'h0000_03FC, 32'hA5A5_5A5A, 4'hF, 1'b0, 32'h0, 1'b1);
        do_req(1'b0, 32'h0000_03FC, 32'h0,         4'h0, 1'b0, 32'hA5A5_5A5A, 1'b1);

        // Partial write and be=0 write
        do_req(1'b1, 32'h0000_0020, 32'h1122_3344, 4'hF,    1'b0, 32'h0, 1'b1);
        do_req(1'b1, 32'h0000_0020, 32'hAABB_CCDD, 4'b0101, 1'b0, 32'h0, 1'b1);
        do_req(1'b0, 32'h0000_0020, 32'h0,         4'h0,    1'b0, 32'h11BB_33DD, 1'b1);
        do_req(1'b1, 32'h0000_0020, 32'hFFFF_FFFF, 4'h0,    1'b0, 32'h0, 1'b1);
        do_req(1'b0, 32'h0000_0020, 32'h0,         4'h0,    1'b0, 32'h11BB_33DD, 1'b1);

        // Misaligned read, out-of-range write, word 0 intact
        do_req(1'b0, 32'h0000_0013, 32'h0,         4'h0, 1'b1, 32'h0, 1'b1);
        do_req(1'b1, 32'h0000_0400, 32'h0BAD_0BAD, 4'hF, 1'b1, 32'h0, 1'b1);
        check("err_count_two", {48'd0, err_count}, 64'd2);
        do_req(1'b0, 32'h0000_0000, 32'h0,         4'h0, 1'b0, 32'h55AA_55AA, 1'b1);

        // Back-pressure: hold rsp_ready low for 5 cycles in RESP
        rsp_ready = 1'b0;
        do_req(1'b0, 32'h0000_0010, 32'h0, 4'h0, 1'b0, 32'hDEAD_BEEF, 1'b0);
        for (int i = 0; i < 5; i++) begin
            req_valid = (i % 2 == 0);
            req_write = 1'b1;
            req_addr  = 32'h0000_0010;
            req_wdata = 32'h0000_0000;
            req_be    = 4'hF;
            @(posedge clk); #1;
            check("bp_rsp_valid", {63'd0, rsp_valid}, 64'd1);
            check("bp_rsp_rdata", {32'd0, rsp_rdata}, {32'd0, 32'hDEAD_BEEF});
            check("bp_rsp_err",   {63'd0, rsp_err}, 64'd0);
            check("bp_req_ready", {63'd0, req_ready}, 64'd0);
            check("bp_state",     {62'd0, dbg_state}, {62'd0, ST_RESP});
        end
        req_valid = 1'b0;
        rsp_ready = 1'b1;
        @(posedge clk); #1;
        check("bp_release_state", {62'd0, dbg_state}, {62'd0, ST_IDLE});
        check("bp_release_ready", {63'd0, req_ready}, 64'd1);
        do_req(1'b0, 32'h0000_0010, 32'h0, 4'h0, 1'b0, 32'hDEAD_BEEF, 1'b1);

        // Reset during ACCESS of a write
        do_req(1'b1, 32'h0000_0030, 32'h1234_5678, 4'hF, 1'b0, 32'h0, 1'b1);
        req_valid = 1'b1;
        req_write = 1'b1;
        req_addr  = 32'h0000_0030;
        req_wdata = 32'hCAFE_F00D;
        req_be    = 4'hF;
        @(posedge clk); #1;
        req_valid = 1'b0;
        check("abort_in_access", {62'd0, dbg_state}, {62'd0, ST_ACCESS});
        reset = 1'b0;
        #1;
        check("abort_req_ready", {63'd0, req_ready}, 64'd0);
        check("abort_rsp_valid", {63'd0, rsp_valid}, 64'd0);
        check("abort_rsp_rdata", {32'd0, rsp_rdata}, 64'd0);
        check("abort_rsp_err",   {63'd0, rsp_err}, 64'd0);
        check("abort_err_count", {48'd0, err_count}, 64'd0);
        check("abort_state",     {62'd0, dbg_state}, {62'd0, ST_IDLE});
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b1;
        #1;
        check("abort_ready_after", {63'd0, req_ready}, 64'd1);
        @(posedge clk); #1;
        check("abort_no_rsp", {63'd0, rsp_valid}, 64'd0);
        do_req(1'b0, 32'h0000_0030, 32'h0, 4'h0, 1'b0, 32'h1234_5678, 1'b1);

        // Saturation
        force dut.err_count_q = 16'hFFFE;
        #1;
        release dut.err_count_q;
        do_req(1'b0, 32'h0000_0001, 32'h0, 4'h0, 1'b1, 32'h0, 1'b1);
        check("sat_first", {48'd0, err_count}, {48'd0, 16'hFFFF});
        do_req(1'b0, 32'h0000_03FE, 32'h0, 4'h0, 1'b1, 32'h0, 1'b1);
        do_req(1'b1, 32'hFFFF_FFFC, 32'h1, 4'hF, 1'b1, 32'h0, 1'b1);
        check("sat_hold", {48'd0, err_count}, {48'd0, 16'hFFFF});

        repeat (3) @(posedge clk);
        #1;
        check("exp_q_empty", 64'(exp_q.size()), 64'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
